// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way select stage.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package mux_pkg;

  // Occupancy state, encoded as {skid valid, main valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  // $clog2(2) is 1 but $clog2(1) is 0; keep the select at least one bit wide.
  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_reg.sv
// One storage entry with a valid bit; clear wins over load.
// Latency: 1 cycle from load to q/valid.
// Backpressure: none internally; the parent decides when to load or clear.
module skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Reset zeroes contents; clear drops only the valid bit so data need not toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-input WIDTH-bit select with a registered, flow-controlled output and 2-entry skid.
// Latency: 1 cycle from accept to out_valid; 1 transfer/cycle while out_ready=1.
// Backpressure: in_ready is a flop that falls one cycle after out_ready drops; skid absorbs the in-flight entry.
module mux_nx1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = safe_clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  // Entry layout: {err, sel, data}.
  localparam int EW = WIDTH + SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  logic             sel_err;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] lane_hit [N];
  logic [WIDTH-1:0] pick;
  logic [EW-1:0]    new_entry;
  logic [EW-1:0]    main_d;
  logic [EW-1:0]    main_q;
  logic [EW-1:0]    skid_q;
  logic             main_vld;
  logic             skid_vld;
  logic             main_load;
  logic             main_clr;
  logic             skid_load;
  logic             skid_clr;
  logic             in_ready_q;
  logic             acc;
  logic             drn;
  state_t           state;
  state_t           nxt_state;

  // Out-of-range selects fall back to the last input, like the default arm of a fixed case.
  assign sel_err = (32'(sel) >= 32'(N));
  assign idx     = sel_err ? LAST_IDX : sel;

  // One masked lane per input; at most one is non-zero.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane_hit[k] = (idx == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : '0;
  end

  // OR-reduce the masked lanes into the selected value.
  always_comb begin
    pick = '0;
    for (int k = 0; k < N; k++) begin
      pick = pick | lane_hit[k];
    end
  end

  assign new_entry = {sel_err, sel, pick};

  assign acc   = in_valid && in_ready_q;
  assign drn   = main_vld && out_ready;
  assign state = state_t'({skid_vld, main_vld});

  // Next-state and storage steering; flush overrides any accept or drain this cycle.
  always_comb begin
    nxt_state = state;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = new_entry;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
      nxt_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            nxt_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            nxt_state = ST_FULL;
          end else if (drn) begin
            main_clr  = 1'b1;
            nxt_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can move things.
          if (drn) begin
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
            nxt_state = ST_ONE;
          end
        end
        default: begin
          // Skid-only is unreachable; recover to empty.
          main_clr  = 1'b1;
          skid_clr  = 1'b1;
          nxt_state = ST_EMPTY;
        end
      endcase
    end
  end

  // in_ready is registered from the next state so no input reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (nxt_state != ST_FULL);
    end
  end

  skid_reg #(.W(EW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q),
    .valid (main_vld)
  );

  skid_reg #(.W(EW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (new_entry),
    .q     (skid_q),
    .valid (skid_vld)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld;
  assign out_data  = main_q[WIDTH-1:0];
  assign out_sel   = main_q[WIDTH +: SEL_W];
  assign out_err   = main_q[EW-1];

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: directed table on N=8, out-of-range on N=5, random scoreboard.
// Latency: expects outputs one edge after accept.
// Backpressure: checks in_ready falls one cycle after out_ready drops and outputs hold while stalled.
module tb_mux_nx1_pipe;

  logic clk;
  logic rst;

  // N=8, WIDTH=32 instance
  logic [255:0] in_data8;
  logic [2:0]   sel8;
  logic         in_valid8, in_ready8, flush8, out_err8, out_valid8, out_ready8;
  logic [31:0]  out_data8;
  logic [2:0]   out_sel8;

  // N=5, WIDTH=16 instance
  logic [79:0]  in_data5;
  logic [2:0]   sel5;
  logic         in_valid5, in_ready5, flush5, out_err5, out_valid5, out_ready5;
  logic [15:0]  out_data5;
  logic [2:0]   out_sel5;

  int checks = 0;
  int errors = 0;

  mux_nx1_pipe #(.WIDTH(32), .N(8)) u8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .sel(sel8), .in_valid(in_valid8),
    .in_ready(in_ready8), .flush(flush8), .out_data(out_data8), .out_sel(out_sel8),
    .out_err(out_err8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  mux_nx1_pipe #(.WIDTH(16), .N(5)) u5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .sel(sel5), .in_valid(in_valid5),
    .in_ready(in_ready5), .flush(flush5), .out_data(out_data5), .out_sel(out_sel5),
    .out_err(out_err5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic        r;
    logic        f;
    logic        eov;
    logic        eir;
    logic [31:0] ed;
    logic [2:0]  es;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  s;
  } ent_t;

  vec_t tbl [24];
  ent_t sb [$];

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic r, input logic f,
                              input logic eov, input logic eir, input logic [31:0] ed, input logic [2:0] es);
    vec_t t;
    t.v = v; t.s = s; t.r = r; t.f = f; t.eov = eov; t.eir = eir; t.ed = ed; t.es = es;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic        hold;
  logic [31:0] snap_d;
  logic [2:0]  snap_s;
  logic        snap_e;
  ent_t        front;

  initial begin
    // Streaming: 0..7 then drain
    for (int k = 0; k < 8; k++) tbl[k] = mk(1, 3'(k), 1, 0, 1, 1, 32'h1000 + k, 3'(k));
    tbl[8]  = mk(0, 0, 1, 0, 0, 1, 0, 0);
    // Stall: out_ready low three cycles, one extra entry lands in skid
    tbl[9]  = mk(1, 0, 1, 0, 1, 1, 32'h1000, 0);
    tbl[10] = mk(1, 1, 1, 0, 1, 1, 32'h1001, 1);
    tbl[11] = mk(1, 2, 0, 0, 1, 0, 32'h1001, 1);
    tbl[12] = mk(1, 3, 0, 0, 1, 0, 32'h1001, 1);
    tbl[13] = mk(1, 3, 0, 0, 1, 0, 32'h1001, 1);
    tbl[14] = mk(1, 3, 1, 0, 1, 1, 32'h1002, 2);
    tbl[15] = mk(1, 3, 1, 0, 1, 1, 32'h1003, 3);
    tbl[16] = mk(0, 0, 1, 0, 0, 1, 0, 0);
    // Flush while FULL with in_valid high, then flush with a live accept
    tbl[17] = mk(1, 4, 0, 0, 1, 1, 32'h1004, 4);
    tbl[18] = mk(1, 5, 0, 0, 1, 0, 32'h1004, 4);
    tbl[19] = mk(1, 6, 0, 1, 0, 1, 0, 0);
    tbl[20] = mk(1, 6, 1, 1, 0, 1, 0, 0);
    tbl[21] = mk(0, 0, 1, 0, 0, 1, 0, 0);
    tbl[22] = mk(1, 7, 1, 0, 1, 1, 32'h1007, 7);
    tbl[23] = mk(0, 0, 1, 0, 0, 1, 0, 0);

    for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = 32'h1000 + k;
    for (int k = 0; k < 4; k++) in_data5[k*16 +: 16] = 16'h0A00 + 16'(k);
    in_data5[4*16 +: 16] = 16'hDEAD;

    rst = 1'b1;
    sel8 = 3'd3; in_valid8 = 1'b1; flush8 = 1'b0; out_ready8 = 1'b1;
    sel5 = 3'd2; in_valid5 = 1'b1; flush5 = 1'b0; out_ready5 = 1'b1;

    // Reset held two cycles with in_valid high
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_out_valid8", out_valid8, 0);
      check("rst_in_ready8",  in_ready8, 1);
      check("rst_out_data8",  out_data8, 0);
      check("rst_out_sel8",   out_sel8, 0);
      check("rst_out_err8",   out_err8, 0);
      check("rst_out_valid5", out_valid5, 0);
      check("rst_in_ready5",  in_ready5, 1);
      check("rst_out_data5",  out_data5, 0);
    end
    rst = 1'b0;
    in_valid8 = 1'b0;
    in_valid5 = 1'b0;
    step();
    check("post_rst_nothing_accepted8", out_valid8, 0);

    // Directed table
    for (int i = 0; i < 24; i++) begin
      in_valid8 = tbl[i].v; sel8 = tbl[i].s; out_ready8 = tbl[i].r; flush8 = tbl[i].f;
      step();
      check($sformatf("tbl%0d_out_valid", i), out_valid8, tbl[i].eov);
      check($sformatf("tbl%0d_in_ready", i), in_ready8, tbl[i].eir);
      if (tbl[i].eov) begin
        check($sformatf("tbl%0d_out_data", i), out_data8, tbl[i].ed);
        check($sformatf("tbl%0d_out_sel", i), out_sel8, tbl[i].es);
        check($sformatf("tbl%0d_out_err", i), out_err8, 0);
      end
    end
    in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b1;

    // Out-of-range select on N=5
    in_valid5 = 1'b1; out_ready5 = 1'b1; sel5 = 3'd6;
    step();
    check("n5_oor_valid", out_valid5, 1);
    check("n5_oor_data", out_data5, 16'hDEAD);
    check("n5_oor_sel", out_sel5, 6);
    check("n5_oor_err", out_err5, 1);
    sel5 = 3'd1;
    step();
    check("n5_sel1_data", out_data5, 16'h0A01);
    check("n5_sel1_sel", out_sel5, 1);
    check("n5_sel1_err", out_err5, 0);
    sel5 = 3'd4;
    step();
    check("n5_sel4_data", out_data5, 16'hDEAD);
    check("n5_sel4_err", out_err5, 0);
    sel5 = 3'd7;
    step();
    check("n5_sel7_data", out_data5, 16'hDEAD);
    check("n5_sel7_sel", out_sel5, 7);
    check("n5_sel7_err", out_err5, 1);
    in_valid5 = 1'b0;
    step();
    check("n5_idle_valid", out_valid5, 0);

    // Random flow control against a scoreboard
    hold = 1'b0; snap_d = '0; snap_s = '0; snap_e = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (hold) begin
        check("rnd_stable_data", out_data8, snap_d);
        check("rnd_stable_sel", out_sel8, snap_s);
        check("rnd_stable_err", out_err8, snap_e);
      end
      check("rnd_out_valid", out_valid8, (sb.size() != 0));
      check("rnd_in_ready", in_ready8, (sb.size() < 2));

      in_valid8  = 1'($urandom_range(0, 1));
      sel8       = 3'($urandom);
      out_ready8 = ($urandom_range(0, 3) != 0);
      flush8     = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = $urandom;

      if (out_valid8 && out_ready8 && sb.size() != 0) begin
        front = sb.pop_front();
        if (!flush8) begin
          check("rnd_order_data", out_data8, front.d);
          check("rnd_order_sel", out_sel8, front.s);
          check("rnd_err", out_err8, 0);
        end
      end
      if (flush8) begin
        sb.delete();
      end else if (in_valid8 && in_ready8) begin
        sb.push_back({in_data8[sel8*32 +: 32], sel8});
      end

      hold   = out_valid8 && !out_ready8 && !flush8;
      snap_d = out_data8;
      snap_s = out_sel8;
      snap_e = out_err8;
      step();
    end

    // Drain what remains and confirm nothing extra appears
    in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid8 && sb.size() != 0) begin
        front = sb.pop_front();
        check("end_order_data", out_data8, front.d);
      end
      step();
    end
    check("end_empty_valid", out_valid8, 0);
    check("end_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
